button_event_ctrl: RTL and testbench

Event controller that sits behind `driver_button` and turns its debounced level (`button_filtered`) into discrete user events: short press, long press and double click. Press and gap durations are timed in units of the shared `tick` strobe. Each event is presented once on a valid/ready output to the consuming logic, such as a menu FSM or register bank. Drops caused by consumer backpressure are flagged.

---
 rtl/button_event_ctrl_pkg.sv | 20 ++
 rtl/button_event_ctrl_if.sv | 24 ++
 rtl/button_event_ctrl_sync_2ff.sv | 26 ++
 rtl/button_event_ctrl.sv | 133 +++++++++++++
 tb/tb_button_event_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the button event controller: event codes and
// FSM state encodings, also used by the menu FSM and the testbench.
package button_event_ctrl_pkg;

    // Event codes presented on evt_code
    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_DOUBLE = 2'b11;

    // Press/gap tracking states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Valid/ready event channel between the button event controller and its
// consumer, plus the sticky overrun flag.
interface button_event_ctrl_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic       evt_overrun;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_overrun,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_overrun,
        output evt_ready
    );

endinterface

// File: rtl/button_event_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reusable for any slow asynchronous control signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: turns a debounced button level into short,
// long and double-click events timed in tick units, delivered once each
// on a valid/ready channel with a sticky drop flag.
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int P_LONG_TICKS   = 100,
    parameter int P_DOUBLE_TICKS = 25,
    parameter int P_CNT_W        = 8
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 button_filtered,
    output logic                 busy,
    button_event_ctrl_if.master  evt
);

    // Counter values at which the deciding tick arrives
    localparam logic [P_CNT_W-1:0] C_LONG_LAST   = P_CNT_W'(P_LONG_TICKS - 1);
    localparam logic [P_CNT_W-1:0] C_DOUBLE_LAST = P_CNT_W'(P_DOUBLE_TICKS - 1);

    logic               w_en_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [P_CNT_W-1:0] r_cnt;
    logic               w_emit;
    logic [1:0]         w_emit_code;
    logic               r_valid;
    logic [1:0]         r_code;
    logic               r_overrun;
    logic               r_busy;

    sync_2ff u_en_sync (
        .clk (aclk),
        .rst (reset),
        .i_d (en),
        .o_q (w_en_s)
    );

    // State register; busy mirrors the state being entered so it matches r_state
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and event decision; thresholds beat release, press beats timeout
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_code = EVT_NONE;
        if (!w_en_s) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (button_filtered) w_state_nxt = ST_PRESS1;
                end
                ST_PRESS1: begin
                    if (tick && (r_cnt == C_LONG_LAST)) begin
                        w_state_nxt = ST_HOLD;
                        w_emit      = 1'b1;
                        w_emit_code = EVT_LONG;
                    end else if (!button_filtered) begin
                        w_state_nxt = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (button_filtered) begin
                        w_state_nxt = ST_PRESS2;
                    end else if (tick && (r_cnt == C_DOUBLE_LAST)) begin
                        w_state_nxt = ST_IDLE;
                        w_emit      = 1'b1;
                        w_emit_code = EVT_SHORT;
                    end
                end
                ST_PRESS2: begin
                    if (!button_filtered) begin
                        w_state_nxt = ST_IDLE;
                        w_emit      = 1'b1;
                        w_emit_code = EVT_DOUBLE;
                    end
                end
                ST_HOLD: begin
                    if (!button_filtered) w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Tick counter: cleared on every state entry, saturates instead of wrapping
    always_ff @(posedge aclk) begin
        if (reset || !w_en_s || (w_state_nxt != r_state)) begin
            r_cnt <= '0;
        end else if (tick && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output event register: load when the slot is free or being drained, else flag a drop
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_code    <= EVT_NONE;
            r_overrun <= 1'b0;
        end else if (w_emit) begin
            if (!r_valid || evt.evt_ready) begin
                r_valid <= 1'b1;
                r_code  <= w_emit_code;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && evt.evt_ready) begin
            r_valid <= 1'b0;
            r_code  <= EVT_NONE;
        end
    end

    assign evt.evt_valid   = r_valid;
    assign evt.evt_code    = r_code;
    assign evt.evt_overrun = r_overrun;
    assign busy            = r_busy;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: stimulus pushes expected events
// (code and the clock edge that should present them), a negedge monitor
// pops and compares every transferred event.
module tb_button_event_ctrl;
    import button_event_ctrl_pkg::*;

    localparam int LONG_T = 10;
    localparam int DBL_T  = 4;

    typedef struct {
        logic [1:0] code;
        int         at;     // edge number that presents the event, -1 = any
    } exp_t;

    logic aclk            = 1'b0;
    logic reset           = 1'b1;
    logic tick            = 1'b0;
    logic en              = 1'b0;
    logic button_filtered = 1'b0;
    logic busy;

    int   ecnt     = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    button_event_ctrl_if evt_if ();

    button_event_ctrl #(
        .P_LONG_TICKS   (LONG_T),
        .P_DOUBLE_TICKS (DBL_T),
        .P_CNT_W        (8)
    ) dut (
        .aclk            (aclk),
        .reset           (reset),
        .tick            (tick),
        .en              (en),
        .button_filtered (button_filtered),
        .busy            (busy),
        .evt             (evt_if.master)
    );

    always #20 aclk = ~aclk;

    // Edge counter
    initial forever begin
        @(posedge aclk);
        ecnt++;
    end

    // Tick is sampled by the DUT at every edge whose number is a multiple of 4
    initial forever begin
        @(posedge aclk);
        #1;
        tick = ((ecnt + 1) % 4 == 0);
    end

    function automatic int nth_tick(input int e, input int n);
        return ((e / 4) + 1) * 4 + (n - 1) * 4;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", nm, act, req, ecnt);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_btn(input logic v);
        button_filtered = v;
        step();
    endtask

    task automatic tick_edges(input int n);
        for (int i = 0; i < n; i++) begin
            do step(); while (ecnt % 4 != 0);
        end
    endtask

    task automatic wait_until(input int e);
        while (ecnt < e) step();
    endtask

    task automatic push(input logic [1:0] c, input int at);
        exp_t x;
        x.code = c;
        x.at   = at;
        q.push_back(x);
    endtask

    // Monitor: every accepted transfer must match the head of the scoreboard
    initial forever begin
        exp_t x;
        @(negedge aclk);
        if (!reset && evt_if.evt_valid && evt_if.evt_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%0d required=none (edge %0d)",
                         evt_if.evt_code, ecnt);
            end else begin
                x = q.pop_front();
                chk("evt_code", int'(evt_if.evt_code), int'(x.code));
                if (x.at >= 0) chk("evt_edge", ecnt, x.at);
            end
        end
    end

    initial begin
        int e;
        int et;
        evt_if.evt_ready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_valid", int'(evt_if.evt_valid), 0);
        chk("rst_code", int'(evt_if.evt_code), 0);
        chk("rst_overrun", int'(evt_if.evt_overrun), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        en    = 1'b1;
        repeat (4) step();

        // Short press: 5 ticks held, SHORT 4 ticks after release
        set_btn(1'b1);
        chk("short_busy_hi", int'(busy), 1);
        tick_edges(5);
        set_btn(1'b0);
        e = ecnt;
        push(EVT_SHORT, nth_tick(e, DBL_T));
        wait_until(nth_tick(e, DBL_T) + 2);
        chk("short_busy_lo", int'(busy), 0);

        // Long press: LONG at the 10th tick while held, nothing on release
        set_btn(1'b1);
        e = ecnt;
        push(EVT_LONG, nth_tick(e, LONG_T));
        tick_edges(15);
        chk("long_hold_busy", int'(busy), 1);
        set_btn(1'b0);
        repeat (3) step();
        chk("long_busy_lo", int'(busy), 0);

        // Double click
        set_btn(1'b1);
        tick_edges(3);
        set_btn(1'b0);
        tick_edges(2);
        set_btn(1'b1);
        tick_edges(3);
        set_btn(1'b0);
        push(EVT_DOUBLE, ecnt);
        tick_edges(6);
        chk("dbl_busy_lo", int'(busy), 0);

        // Backpressure: SHORT held, LONG dropped, overrun set
        evt_if.evt_ready = 1'b0;
        set_btn(1'b1);
        tick_edges(2);
        set_btn(1'b0);
        et = nth_tick(ecnt, DBL_T);
        push(EVT_SHORT, -1);
        wait_until(et);
        chk("bp_valid", int'(evt_if.evt_valid), 1);
        chk("bp_code", int'(evt_if.evt_code), int'(EVT_SHORT));
        chk("bp_overrun0", int'(evt_if.evt_overrun), 0);
        set_btn(1'b1);
        et = nth_tick(ecnt - 1, LONG_T);
        wait_until(et);
        chk("bp_overrun1", int'(evt_if.evt_overrun), 1);
        chk("bp_code_stable", int'(evt_if.evt_code), int'(EVT_SHORT));
        chk("bp_valid_held", int'(evt_if.evt_valid), 1);
        set_btn(1'b0);
        evt_if.evt_ready = 1'b1;
        step();
        chk("bp_valid_drop", int'(evt_if.evt_valid), 0);
        chk("bp_code_drop", int'(evt_if.evt_code), 0);
        repeat (3) step();

        // Release on the same cycle as the 10th tick: LONG wins
        set_btn(1'b1);
        et = nth_tick(ecnt - 1, LONG_T);
        wait_until(et - 1);
        button_filtered = 1'b0;
        push(EVT_LONG, et);
        step();
        chk("sim_long_busy", int'(busy), 1);
        repeat (2) step();
        chk("sim_long_idle", int'(busy), 0);

        // Press on the same cycle as the 4th gap tick: PRESS2, no SHORT
        set_btn(1'b1);
        tick_edges(2);
        set_btn(1'b0);
        et = nth_tick(ecnt, DBL_T);
        wait_until(et - 1);
        button_filtered = 1'b1;
        step();
        chk("sim_gap_busy", int'(busy), 1);
        tick_edges(1);
        set_btn(1'b0);
        push(EVT_DOUBLE, ecnt);
        repeat (3) step();

        // Enable drop during PRESS1: idle within 3 cycles, no events
        set_btn(1'b1);
        tick_edges(2);
        en = 1'b0;
        repeat (3) step();
        chk("en_busy_lo", int'(busy), 0);
        tick_edges(12);
        chk("en_no_event", int'(evt_if.evt_valid), 0);
        set_btn(1'b0);
        en = 1'b1;
        repeat (4) step();

        // Reset with an event pending: everything clears next edge
        evt_if.evt_ready = 1'b0;
        set_btn(1'b1);
        tick_edges(1);
        set_btn(1'b0);
        et = nth_tick(ecnt, DBL_T);
        wait_until(et);
        chk("rp_valid_pre", int'(evt_if.evt_valid), 1);
        reset = 1'b1;
        step();
        chk("rp_valid", int'(evt_if.evt_valid), 0);
        chk("rp_code", int'(evt_if.evt_code), 0);
        chk("rp_overrun", int'(evt_if.evt_overrun), 0);
        chk("rp_busy", int'(busy), 0);
        reset            = 1'b0;
        evt_if.evt_ready = 1'b1;
        repeat (6) step();

        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
